// File: rtl/pc_fetch_unit_if.sv
// IF-stage fetch bundle: hazard/branch controls in, imem request and
// pipe-facing PC/valid/flush out.
interface pc_fetch_unit_if;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        IF_VALID;
  logic        FLUSH;

  modport master (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_BUSYWAIT,
    output IMEM_READ, IMEM_ADDRESS, PC, PC_PLUS4, IF_VALID, FLUSH
  );

  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_BUSYWAIT,
    input  IMEM_READ, IMEM_ADDRESS, PC, PC_PLUS4, IF_VALID, FLUSH
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer for the IF stage.
// Handles stalls, imem busywait and EX redirects with a one-cycle flush.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET,
  pc_fetch_unit_if.master fif
);
  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIRECT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic [31:0] tgt;
  logic [31:0] pc_plus4;

  assign tgt      = fif.BRANCH_TARGET & ~32'h3;
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (fif.BRANCH_TAKEN && !fif.IMEM_BUSYWAIT) begin
          pc_d    = tgt;
          flush_d = 1'b1;
        end else if (fif.BRANCH_TAKEN) begin
          // read in flight: park the target, keep the address steady
          pend_d  = tgt;
          flush_d = 1'b1;
          state_d = REDIRECT;
        end else if (fif.IMEM_BUSYWAIT || fif.STALL) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_plus4;
        end
      end
      REDIRECT: begin
        if (!fif.IMEM_BUSYWAIT) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign fif.PC           = pc_q;
  assign fif.PC_PLUS4     = pc_plus4;
  assign fif.IMEM_ADDRESS = pc_q;
  assign fif.IMEM_READ    = (state_q != BOOT);
  assign fif.IF_VALID     = (state_q == FETCH) && !fif.IMEM_BUSYWAIT
                            && !fif.BRANCH_TAKEN;
  assign fif.FLUSH        = flush_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, stall, redirect,
// busy redirect, wrap-around and reset mid-redirect.
module tb_pc_fetch_unit;
  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_errors;
  int   n_flush;

  pc_fetch_unit_if fif ();
  pc_fetch_unit_if wif ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .fif   (fif.master)
  );

  pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .CLK   (CLK),
    .RESET (RESET),
    .fif   (wif.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_flush  = 0;
    fif.STALL = 0; fif.BRANCH_TAKEN = 0;
    fif.BRANCH_TARGET = 0; fif.IMEM_BUSYWAIT = 0;
    wif.STALL = 0; wif.BRANCH_TAKEN = 0;
    wif.BRANCH_TARGET = 0; wif.IMEM_BUSYWAIT = 0;
    RESET = 1;
    #1;
    check("rst_pc", fif.PC, 32'h0);
    check("rst_pc4", fif.PC_PLUS4, 32'h4);
    check("rst_read", {31'b0, fif.IMEM_READ}, 32'h0);
    check("rst_valid", {31'b0, fif.IF_VALID}, 32'h0);
    check("rst_flush", {31'b0, fif.FLUSH}, 32'h0);
    check("wrap_rst_pc", wif.PC, 32'hFFFF_FFFC);

    // release: one BOOT cycle with no read
    step();
    RESET = 0;
    settle();
    check("boot_read", {31'b0, fif.IMEM_READ}, 32'h0);
    check("boot_valid", {31'b0, fif.IF_VALID}, 32'h0);
    check("boot_pc", fif.PC, 32'h0);

    // sequential fetch 0,4,8,C ; wrap unit FFFFFFFC,0,4
    step();
    check("seq0_addr", fif.IMEM_ADDRESS, 32'h0);
    check("seq0_read", {31'b0, fif.IMEM_READ}, 32'h1);
    check("seq0_valid", {31'b0, fif.IF_VALID}, 32'h1);
    check("wrap0_addr", wif.IMEM_ADDRESS, 32'hFFFF_FFFC);
    check("wrap0_pc4", wif.PC_PLUS4, 32'h0);
    step();
    check("seq1_addr", fif.IMEM_ADDRESS, 32'h4);
    check("seq1_valid", {31'b0, fif.IF_VALID}, 32'h1);
    check("wrap1_addr", wif.IMEM_ADDRESS, 32'h0);
    step();
    check("seq2_addr", fif.IMEM_ADDRESS, 32'h8);
    check("wrap2_addr", wif.IMEM_ADDRESS, 32'h4);
    step();
    check("seq3_addr", fif.IMEM_ADDRESS, 32'hC);
    check("seq3_valid", {31'b0, fif.IF_VALID}, 32'h1);

    // stall two cycles at 0x10
    step();
    fif.STALL = 1;
    settle();
    check("stl0_addr", fif.IMEM_ADDRESS, 32'h10);
    check("stl0_pc4", fif.PC_PLUS4, 32'h14);
    step();
    check("stl1_addr", fif.IMEM_ADDRESS, 32'h10);
    step();
    fif.STALL = 0;
    settle();
    check("stl2_addr", fif.IMEM_ADDRESS, 32'h10);
    check("stl2_pc4", fif.PC_PLUS4, 32'h14);
    step();
    check("stl3_addr", fif.IMEM_ADDRESS, 32'h14);

    // taken branch at 0x20 to misaligned 0x103
    step(); step(); step();
    check("br_pre_pc", fif.PC, 32'h20);
    fif.BRANCH_TAKEN = 1;
    fif.BRANCH_TARGET = 32'h0000_0103;
    settle();
    check("br_valid", {31'b0, fif.IF_VALID}, 32'h0);
    check("br_flush0", {31'b0, fif.FLUSH}, 32'h0);
    step();
    fif.BRANCH_TAKEN = 0;
    settle();
    check("br_pc", fif.PC, 32'h100);
    check("br_flush1", {31'b0, fif.FLUSH}, 32'h1);
    step();
    check("br_pc2", fif.PC, 32'h104);
    check("br_flush2", {31'b0, fif.FLUSH}, 32'h0);

    // get to 0x40 with a plain branch
    fif.BRANCH_TAKEN = 1;
    fif.BRANCH_TARGET = 32'h40;
    step();
    fif.BRANCH_TAKEN = 0;
    settle();
    check("to40_pc", fif.PC, 32'h40);

    // busy for 3 cycles, branch to 0x80 in the first
    fif.IMEM_BUSYWAIT = 1;
    fif.BRANCH_TAKEN = 1;
    fif.BRANCH_TARGET = 32'h80;
    settle();
    check("bz0_addr", fif.IMEM_ADDRESS, 32'h40);
    check("bz0_valid", {31'b0, fif.IF_VALID}, 32'h0);
    step();
    fif.BRANCH_TAKEN = 0;
    fif.BRANCH_TARGET = 32'h0;
    settle();
    n_flush += int'(fif.FLUSH);
    check("bz1_addr", fif.IMEM_ADDRESS, 32'h40);
    check("bz1_flush", {31'b0, fif.FLUSH}, 32'h1);
    check("bz1_valid", {31'b0, fif.IF_VALID}, 32'h0);
    step();
    n_flush += int'(fif.FLUSH);
    check("bz2_addr", fif.IMEM_ADDRESS, 32'h40);
    check("bz2_valid", {31'b0, fif.IF_VALID}, 32'h0);
    step();
    fif.IMEM_BUSYWAIT = 0;
    settle();
    n_flush += int'(fif.FLUSH);
    check("bz3_addr", fif.IMEM_ADDRESS, 32'h40);
    check("bz3_valid", {31'b0, fif.IF_VALID}, 32'h0);
    check("bz3_read", {31'b0, fif.IMEM_READ}, 32'h1);
    step();
    n_flush += int'(fif.FLUSH);
    check("bz4_addr", fif.IMEM_ADDRESS, 32'h80);
    check("bz4_valid", {31'b0, fif.IF_VALID}, 32'h1);
    check("bz_flushes", n_flush, 32'd1);

    // reset in REDIRECT while busy
    step();
    check("r6_pc", fif.PC, 32'h84);
    fif.IMEM_BUSYWAIT = 1;
    fif.BRANCH_TAKEN = 1;
    fif.BRANCH_TARGET = 32'h200;
    step();
    fif.BRANCH_TAKEN = 0;
    settle();
    check("r6_read_pre", {31'b0, fif.IMEM_READ}, 32'h1);
    check("r6_flush_pre", {31'b0, fif.FLUSH}, 32'h1);
    RESET = 1;
    settle();
    check("r6_read", {31'b0, fif.IMEM_READ}, 32'h0);
    check("r6_flush", {31'b0, fif.FLUSH}, 32'h0);
    check("r6_pc0", fif.PC, 32'h0);
    step();
    RESET = 0;
    fif.IMEM_BUSYWAIT = 0;
    settle();
    check("r6_boot", {31'b0, fif.IMEM_READ}, 32'h0);
    step();
    check("r6_addr", fif.IMEM_ADDRESS, 32'h0);
    check("r6_valid", {31'b0, fif.IF_VALID}, 32'h1);
    step();
    check("r6_addr1", fif.IMEM_ADDRESS, 32'h4);

    // branch wins over stall
    fif.STALL = 1;
    fif.BRANCH_TAKEN = 1;
    fif.BRANCH_TARGET = 32'h300;
    step();
    fif.BRANCH_TAKEN = 0;
    settle();
    check("sb_pc", fif.PC, 32'h300);
    check("sb_flush", {31'b0, fif.FLUSH}, 32'h1);
    step();
    check("sb_hold", fif.PC, 32'h300);
    fif.STALL = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
